// File: rtl/regfile_idex.sv
// rtl/regfile_idex.sv - 32x32 register file with write-back bypass feeding an ID/EX pipeline register
module regfile_idex #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [31:0]     instr,
    input  logic [4:0]      r_d,
    input  logic [4:0]      rs_1,
    input  logic [4:0]      rs_2,
    input  logic [11:0]     IMM,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7
);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      ex_rs1_idx;
    logic [4:0]      ex_rs2_idx;
    logic            wb_write;
    logic            load;
    logic            hold;

    // Register-index fields of instr are decoded upstream and arrive on r_d/rs_1/rs_2.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    assign wb_write = wb_en && (wb_rd != 5'd0);
    assign id_ready = !ex_valid || ex_ready;
    assign load     = id_valid && id_ready && !flush;
    assign hold     = ex_valid && !ex_ready;

    always_comb begin
        rs1_val = regs[rs_1];
        if (rs_1 == 5'd0)
            rs1_val = '0;
        else if (wb_en && (wb_rd == rs_1))
            rs1_val = wb_data;
    end

    always_comb begin
        rs2_val = regs[rs_2];
        if (rs_2 == 5'd0)
            rs2_val = '0;
        else if (wb_en && (wb_rd == rs_2))
            rs2_val = wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_write) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_rs1_idx  <= '0;
            ex_rs2_idx  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (load) begin
            ex_valid    <= 1'b1;
            ex_rs1_data <= rs1_val;
            ex_rs2_data <= rs2_val;
            ex_imm      <= {{(XLEN-12){IMM[11]}}, IMM};
            ex_rd       <= r_d;
            ex_opcode   <= instr[6:0];
            ex_funct3   <= instr[14:12];
            ex_funct7   <= instr[31:25];
            ex_rs1_idx  <= rs_1;
            ex_rs2_idx  <= rs_2;
        end else if (hold) begin
            // A write-back landing while stalled refreshes the held operand so it never goes stale.
            if (wb_write && (wb_rd == ex_rs1_idx))
                ex_rs1_data <= wb_data;
            if (wb_write && (wb_rd == ex_rs2_idx))
                ex_rs2_data <= wb_data;
        end else begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_idex.sv
// tb/tb_regfile_idex.sv - randomized and directed checks of regfile_idex against a behavioural model
module tb_regfile_idex;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] instr;
    logic [4:0]  r_d;
    logic [4:0]  rs_1;
    logic [4:0]  rs_2;
    logic [11:0] IMM;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;

    int checks;
    int failures;

    regfile_idex #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .instr(instr), .r_d(r_d), .rs_1(rs_1), .rs_2(rs_2), .IMM(IMM),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view: register contents plus the one in-flight instruction slot.
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_rs1, m_rs2, m_imm, m_instr;
    logic [4:0]  m_rd, m_i1, m_i2;

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return m_regs[idx];
    endfunction

    task automatic model_step();
        logic        accept;
        logic [31:0] a, b;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_instr = 0;
            m_rd = 0; m_i1 = 0; m_i2 = 0;
            return;
        end
        accept = id_valid && (!m_valid || ex_ready) && !flush;
        a = m_read(rs_1);
        b = m_read(rs_2);
        if (flush) begin
            m_valid = 0;
        end else if (accept) begin
            m_valid = 1; m_rs1 = a; m_rs2 = b;
            m_imm = 32'($signed(IMM));
            m_instr = instr; m_rd = r_d; m_i1 = rs_1; m_i2 = rs_2;
        end else if (m_valid && !ex_ready) begin
            if (wb_en && wb_rd != 0 && wb_rd == m_i1) m_rs1 = wb_data;
            if (wb_en && wb_rd != 0 && wb_rd == m_i2) m_rs2 = wb_data;
        end else begin
            m_valid = 0;
        end
        if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare();
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("id_ready", 32'(id_ready), 32'(!m_valid || ex_ready));
        chk("ex_rs1_data", ex_rs1_data, m_rs1);
        chk("ex_rs2_data", ex_rs2_data, m_rs2);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_rd", 32'(ex_rd), 32'(m_rd));
        chk("ex_opcode", 32'(ex_opcode), 32'(m_instr[6:0]));
        chk("ex_funct3", 32'(ex_funct3), 32'(m_instr[14:12]));
        chk("ex_funct7", 32'(ex_funct7), 32'(m_instr[31:25]));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        ex_ready = 1; instr = 0; r_d = 0; rs_1 = 0; rs_2 = 0; IMM = 0;
    endtask

    task automatic capture(input logic [4:0] a, input logic [4:0] b, input logic [11:0] imm);
        id_valid = 1; rs_1 = a; rs_2 = b; IMM = imm;
        r_d = 5'd4; instr = 32'hFE01_A0B3;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle();
        rst = 1;
        @(negedge clk);
        cycle();
        cycle();
        chk("reset ex_valid", 32'(ex_valid), 32'd0);
        chk("reset ex_rs1_data", ex_rs1_data, 32'd0);
        rst = 0;

        // x5 = 0xAA, then read it back with a negative immediate
        wb_en = 1; wb_rd = 5; wb_data = 32'h0000_00AA;
        cycle();
        idle();
        capture(5, 0, 12'hFFF);
        cycle();
        chk("t1 ex_valid", 32'(ex_valid), 32'd1);
        chk("t1 rs1", ex_rs1_data, 32'h0000_00AA);
        chk("t1 rs2", ex_rs2_data, 32'd0);
        chk("t1 imm", ex_imm, 32'hFFFF_FFFF);
        chk("t1 opcode", 32'(ex_opcode), 32'h33);

        // x0 write is ignored and never bypassed
        idle();
        capture(0, 0, 12'h7FF);
        wb_en = 1; wb_rd = 0; wb_data = 32'hDEAD_BEEF;
        cycle();
        chk("t2 x0 bypass", ex_rs1_data, 32'd0);
        chk("t2 imm", ex_imm, 32'h0000_07FF);
        idle();
        capture(0, 0, 12'h0);
        cycle();
        chk("t2 x0 read", ex_rs1_data, 32'd0);

        // same-cycle bypass onto both operands
        idle();
        capture(7, 7, 12'h800);
        wb_en = 1; wb_rd = 7; wb_data = 32'h0000_1234;
        cycle();
        chk("t3 rs1", ex_rs1_data, 32'h0000_1234);
        chk("t3 rs2", ex_rs2_data, 32'h0000_1234);
        chk("t3 imm", ex_imm, 32'hFFFF_F800);

        // stall with write-back refreshing the held operand
        idle();
        wb_en = 1; wb_rd = 3; wb_data = 32'h10;
        cycle();
        idle();
        capture(5, 3, 12'h001);
        cycle();
        chk("t4 rs2 captured", ex_rs2_data, 32'h10);
        idle();
        ex_ready = 0;
        id_valid = 1; rs_1 = 9; rs_2 = 9;
        cycle();
        chk("t4 id_ready c1", 32'(id_ready), 32'd0);
        wb_en = 1; wb_rd = 3; wb_data = 32'h20;
        cycle();
        chk("t4 id_ready c2", 32'(id_ready), 32'd0);
        chk("t4 rs2 refreshed", ex_rs2_data, 32'h20);
        chk("t4 rs1 held", ex_rs1_data, 32'h0000_00AA);
        wb_en = 0;
        cycle();
        chk("t4 id_ready c3", 32'(id_ready), 32'd0);
        chk("t4 valid held", 32'(ex_valid), 32'd1);
        idle();
        cycle();
        chk("t4 drained", 32'(ex_valid), 32'd0);
        chk("t4 data kept", ex_rs2_data, 32'h20);

        // flush drops the offered instruction but not the write-back
        idle();
        capture(5, 0, 12'h0);
        cycle();
        capture(1, 2, 12'h0);
        flush = 1;
        wb_en = 1; wb_rd = 9; wb_data = 32'h99;
        cycle();
        chk("t5 flush valid", 32'(ex_valid), 32'd0);
        idle();
        capture(9, 0, 12'h0);
        cycle();
        chk("t5 wb visible", ex_rs1_data, 32'h99);

        // reset while stalled
        idle();
        capture(5, 9, 12'h0);
        cycle();
        idle();
        ex_ready = 0;
        cycle();
        rst = 1;
        cycle();
        chk("t6 valid", 32'(ex_valid), 32'd0);
        chk("t6 rs1", ex_rs1_data, 32'd0);
        idle();
        capture(5, 9, 12'h0);
        cycle();
        chk("t6 x5 cleared", ex_rs1_data, 32'd0);
        chk("t6 x9 cleared", ex_rs2_data, 32'd0);

        // random traffic with small index range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            id_valid = $urandom_range(0, 1) == 1;
            ex_ready = $urandom_range(0, 9) < 6;
            wb_en    = $urandom_range(0, 1) == 1;
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            instr    = $urandom;
            r_d      = 5'($urandom);
            rs_1     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rs_2     = 5'($urandom_range(0, 7));
            IMM      = 12'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
